// File: rtl/acs_radix2_param_if.sv
// Step/decision bus between the branch-metric unit, the ACS array and traceback.
// The master drives one trellis step per cycle; the slave (ACS array) returns decisions and best state.
interface acs_radix2_param_if #(
    parameter int K    = 3,
    parameter int BM_W = 3,
    parameter int PM_W = 8
);
    localparam int NUM_ST = 2 ** (K - 1);

    logic                       en_acs;
    logic                       i_start;
    logic                       i_last;
    logic [2*NUM_ST*BM_W-1:0]   i_bm;
    logic                       o_dec_valid;
    logic [NUM_ST-1:0]          o_dec;
    logic                       o_norm;
    logic                       o_best_valid;
    logic [K-2:0]               o_best_st;
    logic [PM_W-1:0]            o_best_pm;

    modport master (
        output en_acs, i_start, i_last, i_bm,
        input  o_dec_valid, o_dec, o_norm, o_best_valid, o_best_st, o_best_pm
    );

    modport slave (
        input  en_acs, i_start, i_last, i_bm,
        output o_dec_valid, o_dec, o_norm, o_best_valid, o_best_st, o_best_pm
    );
endinterface

// File: rtl/acs_radix2_param.sv
// Radix-2 add-compare-select array over 2^(K-1) states with normalisation and best-state search.
// One trellis step per clock; all outputs are registered.
module acs_radix2_lane #(
    parameter int BM_W = 3,
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [BM_W-1:0] bm0_i,
    input  logic [BM_W-1:0] bm1_i,
    output logic [PM_W:0]   sel_o,
    output logic            dec_o
);
    logic [PM_W:0] c0, c1;

    assign c0    = (PM_W+1)'(pm0_i) + (PM_W+1)'(bm0_i);
    assign c1    = (PM_W+1)'(pm1_i) + (PM_W+1)'(bm1_i);
    // Ties resolve to the lower predecessor
    assign dec_o = (c1 < c0);
    assign sel_o = dec_o ? c1 : c0;
endmodule

module acs_radix2_param #(
    parameter int K       = 3,
    parameter int BM_W    = 3,
    parameter int PM_W    = 8,
    parameter int INIT_PM = 16
) (
    input  logic                clk,
    input  logic                rst,
    acs_radix2_param_if.slave   acs
);
    localparam int NUM_ST = 2 ** (K - 1);
    localparam int HALF   = 2 ** (PM_W - 1);

    localparam logic [PM_W:0] HALF_V = (PM_W+1)'(HALF);
    localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

    typedef logic [NUM_ST-1:0][PM_W-1:0] pm_vec_t;

    function automatic pm_vec_t init_pm();
        pm_vec_t v;
        for (int s = 0; s < NUM_ST; s++)
            v[s] = (s == 0) ? '0 : PM_W'(INIT_PM);
        return v;
    endfunction

    localparam pm_vec_t PM_INIT = init_pm();

    if (HALF <= INIT_PM + K * (2 ** BM_W - 1)) begin : g_param_check
        $fatal(1, "acs_radix2_param: PM_W too small for INIT_PM/K/BM_W");
    end

    pm_vec_t                    pm_q, pm_d, pm_src, surv;
    logic [NUM_ST-1:0][PM_W:0]  sel;
    logic [NUM_ST-1:0]          dec;
    logic [PM_W:0]              min_v, sub_v, tmp;
    logic                       norm;
    logic [K-2:0]               best_st;
    logic [PM_W-1:0]            best_pm;

    logic [NUM_ST-1:0]          dec_q, dec_d;
    logic                       dec_valid_q, dec_valid_d;
    logic                       norm_q, norm_d;
    logic                       best_valid_q, best_valid_d;
    logic [K-2:0]               best_st_q, best_st_d;
    logic [PM_W-1:0]            best_pm_q, best_pm_d;

    // A start step runs from the initial metrics rather than the stored ones
    assign pm_src = acs.i_start ? PM_INIT : pm_q;

    for (genvar ns = 0; ns < NUM_ST; ns++) begin : g_lane
        localparam int P0 = ns >> 1;
        localparam int P1 = P0 + NUM_ST / 2;
        localparam int U  = ns % 2;

        acs_radix2_lane #(.BM_W(BM_W), .PM_W(PM_W)) u_lane (
            .pm0_i (pm_src[P0]),
            .pm1_i (pm_src[P1]),
            .bm0_i (acs.i_bm[(P0*2+U)*BM_W +: BM_W]),
            .bm1_i (acs.i_bm[(P1*2+U)*BM_W +: BM_W]),
            .sel_o (sel[ns]),
            .dec_o (dec[ns])
        );
    end

    always_comb begin
        min_v = sel[0];
        for (int s = 1; s < NUM_ST; s++)
            if (sel[s] < min_v) min_v = sel[s];
        norm  = (min_v >= HALF_V);
        sub_v = norm ? HALF_V : '0;
        tmp   = '0;
        for (int s = 0; s < NUM_ST; s++) begin
            tmp     = sel[s] - sub_v;
            surv[s] = (tmp > PM_MAX) ? PM_MAX[PM_W-1:0] : tmp[PM_W-1:0];
        end
    end

    // Strict compare keeps the lowest index on ties
    always_comb begin
        best_st = '0;
        best_pm = surv[0];
        for (int s = 1; s < NUM_ST; s++) begin
            if (surv[s] < best_pm) begin
                best_pm = surv[s];
                best_st = (K-1)'(s);
            end
        end
    end

    always_comb begin
        pm_d         = pm_q;
        dec_d        = dec_q;
        dec_valid_d  = 1'b0;
        norm_d       = 1'b0;
        best_valid_d = 1'b0;
        best_st_d    = best_st_q;
        best_pm_d    = best_pm_q;
        if (acs.en_acs) begin
            pm_d        = surv;
            dec_d       = dec;
            dec_valid_d = 1'b1;
            norm_d      = norm;
            if (acs.i_last) begin
                best_valid_d = 1'b1;
                best_st_d    = best_st;
                best_pm_d    = best_pm;
            end
        end else if (acs.i_start) begin
            pm_d = PM_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_q         <= PM_INIT;
            dec_q        <= '0;
            dec_valid_q  <= 1'b0;
            norm_q       <= 1'b0;
            best_valid_q <= 1'b0;
            best_st_q    <= '0;
            best_pm_q    <= '0;
        end else begin
            pm_q         <= pm_d;
            dec_q        <= dec_d;
            dec_valid_q  <= dec_valid_d;
            norm_q       <= norm_d;
            best_valid_q <= best_valid_d;
            best_st_q    <= best_st_d;
            best_pm_q    <= best_pm_d;
        end
    end

    assign acs.o_dec_valid  = dec_valid_q;
    assign acs.o_dec        = dec_q;
    assign acs.o_norm       = norm_q;
    assign acs.o_best_valid = best_valid_q;
    assign acs.o_best_st    = best_st_q;
    assign acs.o_best_pm    = best_pm_q;
endmodule

// File: tb/tb_acs_radix2_param.sv
// Bench for acs_radix2_param: randomized and directed trellis steps checked against
// an integer-array trellis model.
module tb_acs_radix2_param;
    localparam int K = 3, BM_W = 3, PM_W = 8, INIT_PM = 16;
    localparam int NS = 4, BMT = 2 * NS * BM_W, HALF = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    acs_radix2_param_if #(.K(K), .BM_W(BM_W), .PM_W(PM_W)) acs ();

    acs_radix2_param #(.K(K), .BM_W(BM_W), .PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
        .clk (clk),
        .rst (rst),
        .acs (acs)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int mpm[NS];
    int m_dec, m_bst, m_bpm;
    bit m_dv, m_norm, m_bv;

    task automatic model_reset();
        mpm[0] = 0;
        for (int s = 1; s < NS; s++) mpm[s] = INIT_PM;
        m_dec = 0; m_bst = 0; m_bpm = 0;
        m_dv = 0; m_norm = 0; m_bv = 0;
    endtask

    task automatic model_step(input bit en, input bit st, input bit la, input logic [BMT-1:0] bm);
        int base[NS];
        int sel[NS];
        int c0, c1, m, d;
        for (int s = 0; s < NS; s++) base[s] = st ? ((s == 0) ? 0 : INIT_PM) : mpm[s];
        if (!en) begin
            m_dv = 0; m_norm = 0; m_bv = 0;
            if (st) mpm = base;
            return;
        end
        d = 0;
        for (int ns = 0; ns < NS; ns++) begin
            int u, p0, p1;
            u  = ns % 2;
            p0 = ns / 2;
            p1 = p0 + NS / 2;
            c0 = base[p0] + int'(bm[(p0*2+u)*BM_W +: BM_W]);
            c1 = base[p1] + int'(bm[(p1*2+u)*BM_W +: BM_W]);
            if (c1 < c0) begin sel[ns] = c1; d += (1 << ns); end
            else sel[ns] = c0;
        end
        m = sel[0];
        foreach (sel[s]) if (sel[s] < m) m = sel[s];
        m_norm = (m >= HALF);
        foreach (sel[s]) mpm[s] = m_norm ? sel[s] - HALF : sel[s];
        m_dec = d;
        m_dv  = 1;
        m_bv  = la;
        if (la) begin
            m_bst = 0;
            m_bpm = mpm[0];
            for (int s = 1; s < NS; s++)
                if (mpm[s] < m_bpm) begin m_bpm = mpm[s]; m_bst = s; end
        end
    endtask

    function automatic logic [63:0] exp_vec();
        logic [31:0] p;
        for (int s = 0; s < NS; s++) p[s*8 +: 8] = 8'(mpm[s]);
        return {15'b0, m_dv, 4'(m_dec), m_norm, m_bv, 2'(m_bst), 8'(m_bpm), p};
    endfunction

    function automatic logic [63:0] obs_vec();
        return {15'b0, acs.o_dec_valid, acs.o_dec, acs.o_norm, acs.o_best_valid,
                acs.o_best_st, acs.o_best_pm, dut.pm_q};
    endfunction

    function automatic logic [BMT-1:0] bm_all(input int v);
        logic [BMT-1:0] b;
        for (int j = 0; j < 2 * NS; j++) b[j*BM_W +: BM_W] = 3'(v);
        return b;
    endfunction

    function automatic logic [BMT-1:0] bm_rand();
        logic [BMT-1:0] b;
        for (int j = 0; j < 2 * NS; j++) b[j*BM_W +: BM_W] = 3'($urandom_range(0, 7));
        return b;
    endfunction

    // Drive one cycle at the falling edge, advance the model at the rising edge, settle.
    task automatic cycle(input bit en, input bit st, input bit la, input logic [BMT-1:0] bm);
        @(negedge clk);
        acs.en_acs = en; acs.i_start = st; acs.i_last = la; acs.i_bm = bm;
        @(posedge clk);
        model_step(en, st, la, bm);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_hold: got %h want %h", obs_vec(), exp_vec());
        end
        rst = 1'b1;
        cycle(0, 0, 0, '0);
        checks++;
        if (obs_vec() !== exp_vec() || dut.pm_q !== {8'd16, 8'd16, 8'd16, 8'd0}) begin
            errors++; $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_zero_bm(input string name);
        logic [BMT-1:0] b;
        cycle(1, 1, 0, bm_all(0));
        checks++;
        if (acs.o_dec !== 4'b0000 || dut.pm_q !== {8'd16, 8'd16, 8'd0, 8'd0} || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL %s_step1: got %h want %h", name, obs_vec(), exp_vec());
        end
        cycle(1, 0, 0, bm_all(0));
        checks++;
        if (dut.pm_q !== 32'd0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL %s_step2: got %h want %h", name, obs_vec(), exp_vec());
        end
        b = '0; b[2:0] = 3'd7;
        cycle(1, 0, 0, b);
        checks++;
        if (acs.o_dec !== 4'b0001 || dut.pm_q !== 32'd0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL %s_step3: got %h want %h", name, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_norm();
        for (int i = 1; i <= 19; i++) begin
            cycle(1, i == 1, 0, bm_all(7));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL norm_step%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 1 || i == 2 || i == 18 || i == 19) begin
                logic [31:0] want;
                logic        wn;
                want = (i == 1) ? {8'd23, 8'd23, 8'd7, 8'd7} : (i == 2) ? {4{8'd14}} :
                       (i == 18) ? {4{8'd126}} : {4{8'd5}};
                wn   = (i == 19);
                checks++;
                if (dut.pm_q !== want || acs.o_norm !== wn) begin
                    errors++; $display("FAIL norm_const%0d: got pm=%h norm=%b want pm=%h norm=%b",
                                       i, dut.pm_q, acs.o_norm, want, wn);
                end
            end
        end
    endtask

    task automatic test_last();
        logic [BMT-1:0] b;
        b = '0; b[2:0] = 3'd7;
        cycle(1, 1, 0, bm_all(0));
        cycle(1, 0, 0, bm_all(0));
        cycle(1, 0, 1, b);
        checks++;
        if (acs.o_best_valid !== 1'b1 || acs.o_best_st !== 2'd0 || acs.o_best_pm !== 8'd0
            || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL last_pulse: got %h want %h", obs_vec(), exp_vec());
        end
        cycle(1, 0, 0, bm_rand());
        checks++;
        if (acs.o_best_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL last_hold: got %h want %h", obs_vec(), exp_vec());
        end
        // single-step frame; i_last without en_acs is ignored
        cycle(1, 1, 1, bm_rand());
        cycle(0, 0, 1, bm_rand());
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL last_single: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        cycle(1, 1, 0, bm_rand());
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                held = dut.pm_q;
                for (int j = 0; j < 3; j++) begin
                    cycle(0, 0, 0, bm_rand());
                    checks++;
                    if (acs.o_dec_valid !== 1'b0 || dut.pm_q !== held || obs_vec() !== exp_vec()) begin
                        errors++; $display("FAIL stall_idle%0d: got %h want %h", j, obs_vec(), exp_vec());
                    end
                end
            end
            cycle(1, 0, i == 9, bm_rand());
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stall_step%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        // idle start reloads metrics without an output pulse
        cycle(0, 1, 0, bm_rand());
        checks++;
        if (dut.pm_q !== {8'd16, 8'd16, 8'd16, 8'd0} || acs.o_dec_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL idle_start: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0, bm_rand());
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) cycle(1, i == 0, i == 5, bm_rand());
        @(negedge clk);
        acs.en_acs = 1'b1; acs.i_start = 1'b0; acs.i_last = 1'b1; acs.i_bm = bm_all(5);
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_mid: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        acs.en_acs = 1'b0; acs.i_last = 1'b0;
        rst = 1'b1;
        test_zero_bm("after_reset");
    endtask

    initial begin
        acs.en_acs = 1'b0; acs.i_start = 1'b0; acs.i_last = 1'b0; acs.i_bm = '0;
        test_reset();
        test_zero_bm("zero_bm");
        test_norm();
        test_last();
        test_stall();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
